// File: rtl/lcd_frame_streamer.sv
// Raster-scans the pixel memory and streams one RAMWR command plus the whole
// frame of RGB565 pixels to an SPI (mode 0) LCD, one frame per start request.
module lcd_frame_streamer #(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned HEIGHT    = 128,
    parameter int unsigned SCLK_DIV  = 4,
    parameter logic [7:0]  CMD_RAMWR = 8'h2C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  ram_addr_x,
    output logic [7:0]  ram_addr_y,
    input  logic [15:0] ram_data,
    output logic        lcd_sclk,
    output logic        lcd_mosi,
    output logic        lcd_cs_n,
    output logic        lcd_dc,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned CW     = (SCLK_DIV > 1) ? $clog2(2 * SCLK_DIV) : 1;
    localparam logic [CW-1:0] PH_HI  = CW'(SCLK_DIV);
    localparam logic [CW-1:0] PH_END = CW'(2 * SCLK_DIV - 1);
    localparam logic [7:0] X_LAST   = 8'(WIDTH - 1);
    localparam logic [7:0] Y_LAST   = 8'(HEIGHT - 1);
    localparam logic [3:0] CMD_LAST = 4'd7;
    localparam logic [3:0] PIX_LAST = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FETCH,
        ST_PIX,
        ST_DONE
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] ph, ph_d;
    logic [3:0]    bit_cnt, bit_d;
    logic [15:0]   sreg, sreg_d;
    logic [7:0]    x_d, y_d;
    logic          sclk_d, mosi_d, cs_n_d, dc_d, busy_d, done_d;
    logic          shifting;

    // State, counters and all pins registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ph         <= '0;
            bit_cnt    <= '0;
            sreg       <= '0;
            ram_addr_x <= '0;
            ram_addr_y <= '0;
            lcd_sclk   <= 1'b0;
            lcd_mosi   <= 1'b0;
            lcd_cs_n   <= 1'b1;
            lcd_dc     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            ph         <= ph_d;
            bit_cnt    <= bit_d;
            sreg       <= sreg_d;
            ram_addr_x <= x_d;
            ram_addr_y <= y_d;
            lcd_sclk   <= sclk_d;
            lcd_mosi   <= mosi_d;
            lcd_cs_n   <= cs_n_d;
            lcd_dc     <= dc_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

    // Next state; pin values are decoded from the next state so they align with it
    always_comb begin
        state_d = state;
        ph_d    = ph;
        bit_d   = bit_cnt;
        sreg_d  = sreg;
        x_d     = ram_addr_x;
        y_d     = ram_addr_y;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CMD;
                    ph_d    = '0;
                    bit_d   = '0;
                    sreg_d  = {CMD_RAMWR, 8'h00};
                end
            end
            ST_CMD, ST_PIX: begin
                if (ph == PH_END) begin
                    ph_d   = '0;
                    sreg_d = {sreg[14:0], 1'b0};
                    bit_d  = bit_cnt + 4'd1;
                    if (state == ST_CMD && bit_cnt == CMD_LAST) begin
                        state_d = ST_FETCH;
                    end else if (state == ST_PIX && bit_cnt == PIX_LAST) begin
                        if (ram_addr_x == X_LAST && ram_addr_y == Y_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_FETCH;
                            if (ram_addr_x == X_LAST) begin
                                x_d = '0;
                                y_d = ram_addr_y + 8'd1;
                            end else begin
                                x_d = ram_addr_x + 8'd1;
                            end
                        end
                    end
                end else begin
                    ph_d = ph + CW'(1);
                end
            end
            ST_FETCH: begin
                // Cycle 1 lets the address settle, cycle 2 captures the word
                if (ph == '0) begin
                    ph_d = CW'(1);
                end else begin
                    state_d = ST_PIX;
                    ph_d    = '0;
                    bit_d   = '0;
                    sreg_d  = ram_data;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                x_d     = '0;
                y_d     = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        shifting = (state_d == ST_CMD) || (state_d == ST_PIX);
        sclk_d   = shifting && (ph_d >= PH_HI);
        mosi_d   = shifting && sreg_d[15];
        cs_n_d   = !(shifting || state_d == ST_FETCH);
        dc_d     = (state_d == ST_PIX) || (state_d == ST_FETCH);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
    end

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Directed bench for lcd_frame_streamer: four instances with small frames,
// an SPI receiver per instance, and hand-computed expectations.
module tb_lcd_frame_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam int unsigned PW[4] = '{2, 3, 2, 1};
    localparam int unsigned PH[4] = '{2, 2, 2, 1};
    localparam int unsigned PD[4] = '{1, 1, 4, 3};

    logic [3:0]  rst_n_v;
    logic [3:0]  start_v;
    logic [3:0]  use_addr;
    logic [15:0] fix_val[4];

    wire [3:0]  sclk_v, mosi_v, cs_v, dc_v, busy_v, done_v;
    wire [7:0]  ax[4];
    wire [7:0]  ay[4];
    wire [15:0] rd[4];

    int n_total = 0;
    int n_bad   = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign rd[g] = use_addr[g] ? {ax[g], ay[g]} : fix_val[g];

        lcd_frame_streamer #(
            .WIDTH    (PW[g]),
            .HEIGHT   (PH[g]),
            .SCLK_DIV (PD[g]),
            .CMD_RAMWR(8'h2C)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n_v[g]),
            .start     (start_v[g]),
            .ram_addr_x(ax[g]),
            .ram_addr_y(ay[g]),
            .ram_data  (rd[g]),
            .lcd_sclk  (sclk_v[g]),
            .lcd_mosi  (mosi_v[g]),
            .lcd_cs_n  (cs_v[g]),
            .lcd_dc    (dc_v[g]),
            .busy      (busy_v[g]),
            .frame_done(done_v[g])
        );

        int          nbits  = 0;
        int          crise  = 0;
        int          ndone  = 0;
        int          dc_err = 0;
        logic [15:0] sh     = '0;
        logic [7:0]  cmdq[$];
        logic [15:0] pixq[$];

        // SPI receiver: 8 command bits (dc=0) then 16-bit pixel words (dc=1)
        always @(posedge sclk_v[g] or posedge cs_v[g]) begin
            if (cs_v[g] === 1'b1) begin
                nbits = 0;
                crise++;
            end else begin
                sh = {sh[14:0], mosi_v[g]};
                nbits++;
                if (nbits <= 8) begin
                    if (dc_v[g] !== 1'b0) dc_err++;
                    if (nbits == 8) cmdq.push_back(sh[7:0]);
                end else begin
                    if (dc_v[g] !== 1'b1) dc_err++;
                    if ((nbits - 8) % 16 == 0) pixq.push_back(sh);
                end
            end
        end

        always @(posedge clk) if (done_v[g] === 1'b1) ndone++;
    end

    // SCLK phase-length and data-stability monitor for the SCLK_DIV=3 instance
    int   hi_len = 0, lo_len = 0, hi_ok = 0, hi_bad = 0;
    int   lo3 = 0, lo5 = 0, lo_bad = 0, mosi_bad = 0;
    logic seen_hi = 1'b0, prev_mosi = 1'b0;

    always @(negedge clk) begin
        if (sclk_v[3] === 1'b1) begin
            if (lo_len > 0 && seen_hi) begin
                if (lo_len == 3) lo3++;
                else if (lo_len == 5) lo5++;
                else lo_bad++;
            end
            lo_len = 0;
            hi_len++;
            if (mosi_v[3] !== prev_mosi) mosi_bad++;
        end else begin
            if (hi_len > 0) begin
                if (hi_len == 3) hi_ok++;
                else hi_bad++;
                seen_hi = 1'b1;
            end
            hi_len = 0;
            lo_len++;
        end
        prev_mosi = mosi_v[3];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int g);
        start_v[g] = 1'b1;
        tick(1);
        start_v[g] = 1'b0;
    endtask

    // Cycle count is 1 on the first CMD cycle; returns the frame_done cycle
    task automatic wait_done(input int g, input int bound, output int cyc);
        cyc = 1;
        while (done_v[g] !== 1'b1 && cyc < bound) begin
            tick(1);
            cyc++;
        end
        if (done_v[g] !== 1'b1) check("done_timeout", 32'd0, 32'd1);
    endtask

    int cyc, b_cmd, b_pix, b_cr, b_dc, b_dn;
    logic [15:0] exp_w[6];

    initial begin
        rst_n_v  = 4'b0000;
        start_v  = 4'b0000;
        use_addr = 4'b0010;
        fix_val  = '{16'hA5C3, 16'h0000, 16'h1234, 16'hBEEF};
        tick(3);
        for (int g = 0; g < 4; g++) begin
            check("rst_cs_n", 32'(cs_v[g]), 32'd1);
            check("rst_sclk", 32'(sclk_v[g]), 32'd0);
            check("rst_mosi", 32'(mosi_v[g]), 32'd0);
            check("rst_dc",   32'(dc_v[g]), 32'd0);
            check("rst_busy", 32'(busy_v[g]), 32'd0);
            check("rst_done", 32'(done_v[g]), 32'd0);
            check("rst_addr", {16'd0, ax[g], ay[g]}, 32'd0);
        end
        rst_n_v = 4'b1111;
        tick(2);
        check("idle_no_start", 32'(busy_v[0]), 32'd0);

        // Fixed pixel, 2x2, D=1
        b_cmd = g_dut[0].cmdq.size();
        b_pix = g_dut[0].pixq.size();
        b_cr  = g_dut[0].crise;
        b_dc  = g_dut[0].dc_err;
        start_frame(0);
        check("t1_busy", 32'(busy_v[0]), 32'd1);
        check("t1_cs_n", 32'(cs_v[0]), 32'd0);
        check("t1_dc",   32'(dc_v[0]), 32'd0);
        wait_done(0, 2000, cyc);
        check("t1_len", 32'(cyc), 32'd153);
        check("t1_done_cs_n", 32'(cs_v[0]), 32'd1);
        check("t1_done_sclk", 32'(sclk_v[0]), 32'd0);
        check("t1_ncmd", 32'(g_dut[0].cmdq.size() - b_cmd), 32'd1);
        check("t1_cmd", 32'(g_dut[0].cmdq[b_cmd]), 32'h2C);
        check("t1_npix", 32'(g_dut[0].pixq.size() - b_pix), 32'd4);
        for (int i = 0; i < 4; i++)
            check("t1_pix", 32'(g_dut[0].pixq[b_pix + i]), 32'hA5C3);
        check("t1_cs_rises", 32'(g_dut[0].crise - b_cr), 32'd1);
        check("t1_dc_err", 32'(g_dut[0].dc_err - b_dc), 32'd0);
        tick(1);
        check("t1_done_pulse", 32'(done_v[0]), 32'd0);
        check("t1_idle_busy", 32'(busy_v[0]), 32'd0);
        check("t1_addr_home", {16'd0, ax[0], ay[0]}, 32'd0);

        // start during PIX is ignored; then start held high
        b_dn = g_dut[0].ndone;
        start_frame(0);
        tick(40);
        start_v[0] = 1'b1;
        tick(1);
        start_v[0] = 1'b0;
        wait_done(0, 2000, cyc);
        tick(100);
        check("t4_one_done", 32'(g_dut[0].ndone - b_dn), 32'd1);
        check("t4_idle", 32'(busy_v[0]), 32'd0);
        start_v[0] = 1'b1;
        tick(1);
        wait_done(0, 2000, cyc);
        tick(1);
        check("t4_gap_idle", 32'(busy_v[0]), 32'd0);
        tick(1);
        check("t4_recmd_busy", 32'(busy_v[0]), 32'd1);
        check("t4_recmd_cs_n", 32'(cs_v[0]), 32'd0);
        check("t4_recmd_dc",   32'(dc_v[0]), 32'd0);
        start_v[0] = 1'b0;
        wait_done(0, 2000, cyc);
        tick(2);

        // Address-derived data, 3x2
        exp_w = '{16'h0000, 16'h0100, 16'h0200, 16'h0001, 16'h0101, 16'h0201};
        b_pix = g_dut[1].pixq.size();
        start_frame(1);
        wait_done(1, 2000, cyc);
        check("t2_len", 32'(cyc), 32'd221);
        check("t2_npix", 32'(g_dut[1].pixq.size() - b_pix), 32'd6);
        for (int i = 0; i < 6; i++)
            check("t2_word", 32'(g_dut[1].pixq[b_pix + i]), 32'(exp_w[i]));
        tick(1);
        check("t2_addr_home", {16'd0, ax[1], ay[1]}, 32'd0);

        // Data changes right after capture: first word keeps the captured value
        use_addr[1] = 1'b0;
        fix_val[1]  = 16'h1111;
        b_pix = g_dut[1].pixq.size();
        start_frame(1);
        tick(17);
        tick(1);
        fix_val[1] = 16'h2222;
        wait_done(1, 2000, cyc);
        check("t3_first", 32'(g_dut[1].pixq[b_pix]), 32'h1111);
        check("t3_second", 32'(g_dut[1].pixq[b_pix + 1]), 32'h2222);
        tick(2);

        // Reset mid-PIX with D=4, then a clean full frame
        start_frame(2);
        tick(71);
        check("t5_pre_sclk", 32'(sclk_v[2]), 32'd1);
        check("t5_pre_dc", 32'(dc_v[2]), 32'd1);
        rst_n_v[2] = 1'b0;
        #1;
        check("t5_rst_cs_n", 32'(cs_v[2]), 32'd1);
        check("t5_rst_sclk", 32'(sclk_v[2]), 32'd0);
        check("t5_rst_busy", 32'(busy_v[2]), 32'd0);
        tick(2);
        rst_n_v[2] = 1'b1;
        tick(1);
        b_cmd = g_dut[2].cmdq.size();
        b_pix = g_dut[2].pixq.size();
        b_dc  = g_dut[2].dc_err;
        start_frame(2);
        check("t5_addr_start", {16'd0, ax[2], ay[2]}, 32'd0);
        wait_done(2, 3000, cyc);
        check("t5_len", 32'(cyc), 32'd585);
        check("t5_cmd", 32'(g_dut[2].cmdq[b_cmd]), 32'h2C);
        check("t5_npix", 32'(g_dut[2].pixq.size() - b_pix), 32'd4);
        for (int i = 0; i < 4; i++)
            check("t5_pix", 32'(g_dut[2].pixq[b_pix + i]), 32'h1234);
        check("t5_dc_err", 32'(g_dut[2].dc_err - b_dc), 32'd0);
        tick(2);

        // D=3 phase lengths on a 1x1 frame
        start_frame(3);
        wait_done(3, 2000, cyc);
        tick(2);
        check("t6_len", 32'(cyc), 32'd147);
        check("t6_hi_ok", 32'(hi_ok), 32'd24);
        check("t6_hi_bad", 32'(hi_bad), 32'd0);
        check("t6_lo3", 32'(lo3), 32'd22);
        check("t6_lo5", 32'(lo5), 32'd1);
        check("t6_lo_bad", 32'(lo_bad), 32'd0);
        check("t6_mosi_stable", 32'(mosi_bad), 32'd0);
        check("t6_cmd", 32'(g_dut[3].cmdq[0]), 32'h2C);
        check("t6_pix", 32'(g_dut[3].pixq[0]), 32'hBEEF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
